// File: rtl/fp_sched_pkg.sv
// Shared widths and FSM state encoding for the floating-point adder scheduler.
package fp_sched_pkg;

    localparam int FRAC_W = 5;
    localparam int EXP_W  = 4;

    typedef enum logic [2:0] {
        IDLE,
        ARB,
        START,
        WAIT_DONE,
        RESP,
        DRAIN
    } state_t;

endpackage

// File: rtl/fp_adder_scheduler_arbiter.sv
// Combinational round-robin arbiter: grants the first request at or above ptr, wrapping.
module rr_arbiter #(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]         req,
    input  logic [$clog2(NREQ)-1:0] ptr,
    output logic [NREQ-1:0]         gnt
);

    logic found;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        gnt   = '0;
        found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!found && req[i] && (i == (int'(ptr) + k) % NREQ)) begin
                    gnt[i] = 1'b1;
                    found  = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/fp_adder_scheduler.sv
// Shares one floating_point_Adder among NREQ requesters with round-robin arbitration
// and a watchdog that aborts a transaction when the adder never raises Done.
module fp_adder_scheduler
    import fp_sched_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 31
) (
    input  logic                   CLK,
    input  logic                   nRST,
    input  logic [NREQ-1:0]        Req,
    input  logic [FRAC_W*NREQ-1:0] ReqF1,
    input  logic [FRAC_W*NREQ-1:0] ReqF2,
    input  logic [EXP_W*NREQ-1:0]  ReqE1,
    input  logic [EXP_W*NREQ-1:0]  ReqE2,
    output logic [NREQ-1:0]        Gnt,
    output logic [NREQ-1:0]        RspValid,
    output logic [FRAC_W-1:0]      ResF,
    output logic [EXP_W-1:0]       ResE,
    output logic                   ResV,
    output logic                   ResErr,
    output logic                   St,
    output logic [FRAC_W-1:0]      F1,
    output logic [FRAC_W-1:0]      F2,
    output logic [EXP_W-1:0]       E1,
    output logic [EXP_W-1:0]       E2,
    input  logic [FRAC_W-1:0]      AddF,
    input  logic [EXP_W-1:0]       AddE,
    input  logic                   AddV,
    input  logic                   Done
);

    localparam int PTR_W = $clog2(NREQ);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    state_t            state;
    logic [PTR_W-1:0]  ptr;
    logic [PTR_W-1:0]  gnt_idx;
    logic [PTR_W-1:0]  ptr_next;
    logic [CNT_W-1:0]  cnt;
    logic [NREQ-1:0]   arb_gnt;
    logic [FRAC_W-1:0] sel_f1;
    logic [FRAC_W-1:0] sel_f2;
    logic [EXP_W-1:0]  sel_e1;
    logic [EXP_W-1:0]  sel_e2;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req (Req),
        .ptr (ptr),
        .gnt (arb_gnt)
    );

    // One-hot operand mux for the arbitration winner, and the index of the held grant.
    always_comb begin
        sel_f1  = '0;
        sel_f2  = '0;
        sel_e1  = '0;
        sel_e2  = '0;
        gnt_idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (arb_gnt[i]) begin
                sel_f1 = ReqF1[FRAC_W*i +: FRAC_W];
                sel_f2 = ReqF2[FRAC_W*i +: FRAC_W];
                sel_e1 = ReqE1[EXP_W*i +: EXP_W];
                sel_e2 = ReqE2[EXP_W*i +: EXP_W];
            end
            if (Gnt[i]) begin
                gnt_idx = PTR_W'(i);
            end
        end
    end

    assign ptr_next = (gnt_idx == PTR_W'(NREQ - 1)) ? '0 : gnt_idx + PTR_W'(1);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state    <= IDLE;
            ptr      <= '0;
            cnt      <= '0;
            Gnt      <= '0;
            RspValid <= '0;
            ResF     <= '0;
            ResE     <= '0;
            ResV     <= 1'b0;
            ResErr   <= 1'b0;
            St       <= 1'b0;
            F1       <= '0;
            F2       <= '0;
            E1       <= '0;
            E2       <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
            case (state)
                IDLE: begin
                    // Holding off while Done is high keeps a stale completion from being taken as ours.
                    if (|Req && !Done) state <= ARB;
                end
                ARB: begin
                    if (|arb_gnt) begin
                        Gnt   <= arb_gnt;
                        F1    <= sel_f1;
                        F2    <= sel_f2;
                        E1    <= sel_e1;
                        E2    <= sel_e2;
                        St    <= 1'b1;
                        state <= START;
                    end else begin
                        state <= IDLE;
                    end
                end
                START: begin
                    St    <= 1'b0;
                    cnt   <= '0;
                    state <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    cnt <= cnt + CNT_W'(1);
                    if (Done) begin
                        ResF   <= AddF;
                        ResE   <= AddE;
                        ResV   <= AddV;
                        ResErr <= 1'b0;
                        state  <= RESP;
                    end else if (cnt == CNT_W'(TIMEOUT)) begin
                        ResF   <= '0;
                        ResE   <= '0;
                        ResV   <= 1'b0;
                        ResErr <= 1'b1;
                        state  <= RESP;
                    end
                end
                RESP: begin
                    RspValid <= Gnt;
                    ptr      <= ptr_next;
                    state    <= DRAIN;
                end
                DRAIN: begin
                    RspValid <= '0;
                    Gnt      <= '0;
                    if (!Done) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/fp_adder_scheduler.md
# fp_adder_scheduler

Round-robin scheduler that shares one `floating_point_Adder` instance among `NREQ` requesters. It arbitrates the requests and latches the winner's operands. It then drives the adder's `St`/`Done` handshake and returns the result to the winning requester. A watchdog aborts the transaction if the adder never answers. The block sits between the requester ports and the adder, which it drives directly.

## Interface
- `NREQ`, default 4: number of requesters, 2..8.
- `TIMEOUT`, default 31: maximum cycles to wait for `Done` before an abort.
- `CLK` in 1: single clock, rising edge.
- `nRST` in 1: reset, asynchronous, active-low.
- `Req` in `NREQ`: per-requester request level. Held until that requester's `RspValid` bit.
- `ReqF1`, `ReqF2` in 5*`NREQ`: packed fractions. Requester i occupies `[5i+4:5i]`.
- `ReqE1`, `ReqE2` in 4*`NREQ`: packed exponents. Requester i occupies `[4i+3:4i]`.
- `Gnt` in-block output `NREQ`: one-hot, high from grant through `RspValid`. All zero otherwise.
- `RspValid` out `NREQ`: one-hot, 1-cycle pulse marking a result for requester i.
- `ResF` out 5: result fraction. Valid when any `RspValid` is high.
- `ResE` out 4: result exponent. Valid when any `RspValid` is high.
- `ResV` out 1: overflow flag. Valid when any `RspValid` is high.
- `ResErr` out 1: timeout abort. Valid when any `RspValid` is high.
- `St` out 1: adder start pulse.
- `F1`, `F2` out 5: adder fraction operands.
- `E1`, `E2` out 4: adder exponent operands.
- `AddF` in 5: adder result fraction.
- `AddE` in 4: adder result exponent.
- `AddV` in 1: adder overflow flag.
- `Done` in 1: adder completion. Level high for 1 or more cycles.

## Operation
- Reset values: all outputs 0, round-robin pointer `ptr` = 0, state IDLE, timeout counter = 0.
- States:
  - **IDLE**: if `Req` is nonzero and `Done` is 0, go to ARB. Never start while `Done` is 1; this covers an adder still finishing when reset was released.
  - **ARB**: grant the first requester at or after `ptr` with `Req` high, searching upward with wrap. Set its `Gnt`. Latch its operands into `F1`/`F2`/`E1`/`E2`. Go to START.
  - **START**: `St` = 1 for exactly one cycle. Clear the counter. Go to WAIT_DONE.
  - **WAIT_DONE**: each cycle, increment the counter.
    - If `Done` = 1: capture `AddF`/`AddE`/`AddV` into `ResF`/`ResE`/`ResV`. Set `ResErr` = 0. Go to RESP.
    - Else if counter = `TIMEOUT`: set `ResF`/`ResE`/`ResV` = 0 and `ResErr` = 1. Go to RESP.
    - If `Done` and the timeout occur in the same cycle, `Done` wins.
  - **RESP**: pulse `RspValid[g]` for one cycle. Set `ptr` = (g+1) mod `NREQ`. Go to DRAIN.
  - **DRAIN**: deassert `Gnt`. Wait for `Done` = 0, then go to IDLE. On the timeout path `Done` is already 0, so DRAIN lasts one cycle.
- `F1`/`F2`/`E1`/`E2` hold their latched values from ARB until the next ARB, so they are stable throughout the adder operation.
- `ResF`/`ResE`/`ResV`/`ResErr` hold their values until the next capture.
- A requester that drops `Req` before its grant is simply skipped. Dropping `Req` after the grant has no effect; the transaction completes.
- `nRST` asserted mid-operation clears everything immediately. The in-flight result is lost and no `RspValid` is issued.

## Timing
- Best case from `Req` high in IDLE to `St`: IDLE at cycle 0, ARB at cycle 1, `St` at cycle 2.
- `RspValid` arrives 2 cycles after the first `Done` = 1 sample: one cycle to capture, then RESP.
- Throughput is one transaction per (adder latency + `Done` high time + 5) cycles.
- Fairness: a requester waits for at most `NREQ`-1 other transactions.
- `St` is never asserted while `Done` = 1. Two `St` pulses are always separated by at least one `Done` = 0 cycle.

## Structure
- Package `fp_sched_pkg` holds:
  - the state enum `IDLE`, `ARB`, `START`, `WAIT_DONE`, `RESP`, `DRAIN`;
  - the widths `FRAC_W` = 5 and `EXP_W` = 4.
- Sub-module `rr_arbiter`: combinational, with inputs `req` and `ptr` and output one-hot `gnt`, parameterized by `NREQ`. The FSM registers its output in ARB.
- Estimated size is 150–250 lines.

## Test plan
- **Single request.** Adder stub with 3-cycle latency and `Done` high for 1 cycle, returning `AddF` = 01000, `AddE` = 1011, `AddV` = 0. Requester 2 drives `ReqF1` = 01010, `ReqE1` = 1001, `ReqF2` = 01100, `ReqE2` = 1010.
  - `St` 2 cycles after `Req`, with operands exactly as driven.
  - `RspValid` = 0100, `ResF` = 01000, `ResE` = 1011, `ResErr` = 0.
  - `ptr` = 3 afterwards.
- **Round-robin.** All four `Req` held with `ptr` = 0: grants in order 0, 1, 2, 3, 0, each with exactly one `St`.
- **Wrap.** `Req` = 0011 with `ptr` = 3: requester 0 is served first, then requester 1.
- **Timeout.** Stub never asserts `Done`, `TIMEOUT` = 31: `RspValid` occurs with `ResErr` = 1, `ResF` = 0, and no second `St` for that request.
- **Long `Done`.** Stub holds `Done` high for 4 cycles: exactly one `RspValid`, and the next `St` comes only after `Done` falls.
- **Reset mid-operation.** `nRST` pulled low during WAIT_DONE:
  - all outputs read 0 immediately and no `RspValid` is issued;
  - if `Done` is high when reset releases, `St` waits until `Done` = 0.
